// File: rtl/phj_pkg.sv
// Shared constants and helpers for the partitioned hash join datapath.
// Hash constants follow the murmur3 fmix32 finalizer.
package phj_pkg;

  localparam int unsigned TUPLE_W    = 64;
  localparam int unsigned KEY_W      = 32;
  localparam int unsigned HASH_W     = 32;
  localparam int unsigned NUM_STAGES = 4;

  localparam logic [HASH_W-1:0] FMIX_C1 = 32'h85EB_CA6B;
  localparam logic [HASH_W-1:0] FMIX_C2 = 32'hC2B2_AE35;

  function automatic logic [HASH_W-1:0] xorshift(input logic [HASH_W-1:0] h,
                                                 input int unsigned       sh);
    return h ^ (h >> sh);
  endfunction

endpackage

// File: rtl/tuple_hasher.sv
// Four-stage fmix32 hashing pipeline that tags each tuple with its index in the relation.
// One relation at a time: intake stalls after a last tuple until that tuple leaves.
module tuple_hasher
  import phj_pkg::*;
#(
  parameter logic [31:0] SEED     = 32'h0000_0000,
  parameter int unsigned SERIAL_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [TUPLE_W-1:0]  in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TUPLE_W-1:0]  out_data,
  output logic [HASH_W-1:0]   out_hash,
  output logic                out_last,
  output logic [SERIAL_W-1:0] out_serialnum
);

  localparam int unsigned LastSt = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] last_q;
  logic [TUPLE_W-1:0]    data_q   [NUM_STAGES];
  logic [HASH_W-1:0]     hash_q   [NUM_STAGES];
  logic [HASH_W-1:0]     hash_d   [NUM_STAGES];
  logic [SERIAL_W-1:0]   serial_q [NUM_STAGES];
  logic [SERIAL_W-1:0]   count_q, count_d;
  logic                  draining_q, draining_d;
  logic                  en, accept, last_out_xfer;

  // Whole pipeline moves in lockstep; only a stalled full output stage blocks it.
  assign en            = !valid_q[LastSt] || out_ready;
  assign in_ready      = en && !draining_q && !reset;
  assign accept        = in_valid && in_ready;
  assign last_out_xfer = valid_q[LastSt] && out_ready && last_q[LastSt];

  always_comb begin
    hash_d[0] = xorshift(in_data[KEY_W-1:0] ^ SEED, 16);
    hash_d[1] = hash_q[0] * FMIX_C1;
    hash_d[2] = xorshift(hash_q[1], 13) * FMIX_C2;
    hash_d[3] = xorshift(hash_q[2], 16);
  end

  always_comb begin
    count_d    = count_q;
    draining_d = draining_q;
    if (accept) begin
      count_d = count_q + SERIAL_W'(1);
      if (in_last) draining_d = 1'b1;
    end
    // Acceptance is blocked while draining, so this never collides with an accept.
    if (last_out_xfer) begin
      count_d    = '0;
      draining_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      last_q     <= '0;
      count_q    <= '0;
      draining_q <= 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        data_q[i]   <= '0;
        hash_q[i]   <= '0;
        serial_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      draining_q <= draining_d;
      if (en) begin
        valid_q     <= {valid_q[NUM_STAGES-2:0], accept};
        last_q      <= {last_q[NUM_STAGES-2:0], accept && in_last};
        data_q[0]   <= in_data;
        hash_q[0]   <= hash_d[0];
        serial_q[0] <= count_q;
        for (int i = 1; i < NUM_STAGES; i++) begin
          data_q[i]   <= data_q[i-1];
          hash_q[i]   <= hash_d[i];
          serial_q[i] <= serial_q[i-1];
        end
      end
    end
  end

  assign out_valid     = valid_q[LastSt];
  assign out_last      = last_q[LastSt];
  assign out_data      = data_q[LastSt];
  assign out_hash      = hash_q[LastSt];
  assign out_serialnum = serial_q[LastSt];

endmodule

// File: tb/tb_tuple_hasher.sv
// Scoreboard bench for tuple_hasher: driver pushes expected tuples on acceptance,
// monitor pops and compares on every output transfer.
module tb_tuple_hasher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready2;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid, out_valid2;
  logic        out_ready = 1'b1;
  logic [63:0] out_data, out_data2;
  logic [31:0] out_hash, out_hash2;
  logic        out_last, out_last2;
  logic [63:0] out_serialnum, out_serialnum2;

  always #5 clk = ~clk;

  tuple_hasher #(.SEED(32'h0000_0000), .SERIAL_W(64)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_hash     (out_hash),
    .out_last     (out_last),
    .out_serialnum(out_serialnum)
  );

  tuple_hasher #(.SEED(32'hDEAD_BEEF), .SERIAL_W(64)) u_dut_seed (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready2),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid2),
    .out_ready    (out_ready),
    .out_data     (out_data2),
    .out_hash     (out_hash2),
    .out_last     (out_last2),
    .out_serialnum(out_serialnum2)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [63:0] serial;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_stall = -1;
  int          drain_cyc = 0;
  bit          tb_drain = 1'b0;
  logic [63:0] model_serial = '0;
  bit          stop_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fmix(input logic [31:0] k);
    logic [31:0] h;
    h = k;
    h = h ^ (h >> 16);
    h = h * 32'h85EBCA6B;
    h = h ^ (h >> 13);
    h = h * 32'hC2B2AE35;
    h = h ^ (h >> 16);
    return h;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called at a negedge; returns at a negedge once the tuple is accepted.
  task automatic send(input logic [63:0] d, input logic l);
    int n;
    bit done;
    exp_t e;
    n = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!done) begin
      #2;
      if (in_ready) begin
        e.data   = d;
        e.last   = l;
        e.serial = model_serial;
        e.cyc    = cyc;
        q.push_back(e);
        if (l) begin
          model_serial = '0;
          tb_drain     = 1'b1;
          drain_cyc    = cyc;
        end else begin
          model_serial = model_serial + 64'd1;
        end
        done = 1'b1;
      end
      @(negedge clk);
      if (!done) begin
        n++;
        if (n > 300) begin
          n_checks++;
          $display("FAIL send_timeout: tuple %h not accepted within 300 cycles", d);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_last  = 1'($urandom);
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    q.delete();
    model_serial = '0;
    tb_drain     = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_empty(input int limit);
    int n;
    n = 0;
    while (q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);
  endtask

  // Monitor
  initial begin
    bit          prev_reset;
    bit          prev_hold;
    logic [63:0] p_data, p_serial;
    logic [31:0] p_hash;
    logic        p_last;
    exp_t        e;
    prev_reset = 1'b0;
    prev_hold  = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        chk("in_ready_in_reset", 64'(in_ready), 64'd0);
        prev_reset = 1'b1;
        prev_hold  = 1'b0;
      end else begin
        if (prev_reset) begin
          chk("rst_out_valid", 64'(out_valid), 64'd0);
          chk("rst_out_last", 64'(out_last), 64'd0);
          chk("rst_out_hash", 64'(out_hash), 64'd0);
          chk("rst_out_data", out_data, 64'd0);
          chk("rst_out_serial", out_serialnum, 64'd0);
          prev_reset = 1'b0;
        end
        if (tb_drain && cyc > drain_cyc) begin
          chk("drain_in_ready", 64'(in_ready), 64'd0);
          chk("drain_in_ready_seed", 64'(in_ready2), 64'd0);
        end
        if (prev_hold) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_data", out_data, p_data);
          chk("hold_hash", 64'(out_hash), 64'(p_hash));
          chk("hold_last", 64'(out_last), 64'(p_last));
          chk("hold_serial", out_serialnum, p_serial);
        end
        if (!out_ready) last_stall = cyc;
        if (out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: got data %h serial %0d with no tuple pending",
                     out_data, out_serialnum);
          end else begin
            e = q.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_last", 64'(out_last), 64'(e.last));
            chk("out_serial", out_serialnum, e.serial);
            chk("out_hash", 64'(out_hash), 64'(fmix(e.data[31:0])));
            chk("seed_valid", 64'(out_valid2), 64'd1);
            chk("seed_hash", 64'(out_hash2), 64'(fmix(e.data[31:0] ^ 32'hDEADBEEF)));
            chk("seed_serial", out_serialnum2, e.serial);
            if (e.cyc > last_stall) chk("latency", 64'(cyc - e.cyc), 64'd4);
            if (e.last) tb_drain = 1'b0;
          end
        end
        prev_hold = out_valid && !out_ready;
        p_data    = out_data;
        p_hash    = out_hash;
        p_last    = out_last;
        p_serial  = out_serialnum;
      end
    end
  end

  // Driver
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single one-tuple relation, all-zero key.
    send(64'h0, 1'b1);
    wait_empty(50);

    // Streaming keys 1..16.
    for (int k = 1; k <= 16; k++) send({$urandom, 32'(k)}, k == 16);
    wait_empty(50);

    // Backpressure mid-stream.
    fork
      begin
        for (int i = 0; i < 20; i++) send({$urandom, $urandom}, i == 19);
      end
      begin
        repeat (8) @(negedge clk);
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_empty(60);

    // Next relation held off while the previous one drains.
    send({$urandom, $urandom}, 1'b1);
    send({$urandom, $urandom}, 1'b0);
    send({$urandom, $urandom}, 1'b1);
    wait_empty(50);

    // Reset with three tuples in flight.
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 1'b0);
    do_reset(1);
    send({$urandom, $urandom}, 1'b1);
    wait_empty(50);

    // Seeded instance hashes this key to zero.
    send({$urandom, 32'hDEADBEEF}, 1'b1);
    wait_empty(50);

    // Random traffic with gaps, random relation lengths and random backpressure.
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(3) == 0) @(negedge clk);
          send({$urandom, $urandom}, $urandom_range(7) == 0);
        end
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(negedge clk);
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_empty(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tuple_hasher.md
TUPLE_HASHER -- requirements
Module: tuple_hasher

Interface
REQ-001 SHALL have parameter SEED, default 32'h0000_0000, XORed into the key before hashing.
REQ-002 SHALL have parameter SERIAL_W, default 64, the width of the serial number.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream tuple valid.
REQ-006 SHALL have port in_ready  output  1  tuple accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data  input  64  tuple; bits [31:0] are the join key.
REQ-008 SHALL have port in_last  input  1  marks the final tuple of a relation.
REQ-009 SHALL have port out_valid  output  1  hashed tuple valid toward the hash table.
REQ-010 SHALL have port out_ready  input  1  downstream accept; a transfer occurs when out_valid && out_ready.
REQ-011 SHALL have port out_data  output  64  the unmodified in_data.
REQ-012 SHALL have port out_hash  output  32  hash of the key; the consumer uses the low ROW_BITS bits as the row address.
REQ-013 SHALL have port out_last  output  1  in_last carried with the tuple.
REQ-014 SHALL have port out_serialnum  output  SERIAL_W  per-relation index of the tuple.

Function
REQ-015 SHALL compute h = key ^ SEED, then h ^= h>>16, h *= 32'h85EBCA6B, h ^= h>>13, h *= 32'hC2B2AE35, h ^= h>>16.
- Every multiply is modulo 2^32.
- This is the murmur3 fmix32 finalizer.
REQ-016 SHALL pipeline the hash in 4 stages, one register each:
- S1: XOR with SEED, then XOR with >>16.
- S2: first multiply.
- S3: XOR with >>13, then second multiply.
- S4: XOR with >>16.
REQ-017 SHALL carry data, last, serialnum and a valid bit alongside the hash in every stage.
REQ-018 SHALL present an accepted tuple on the outputs exactly 4 cycles after acceptance when out_ready is held high.
REQ-019 SHALL advance all stages together only when en = !S4.valid || out_ready; when en is low, every stage SHALL hold.
- Full throughput: one tuple per cycle when unstalled.
REQ-020 SHALL drive in_ready = en && !draining, combinationally.
REQ-021 SHALL assign each accepted tuple the current serial count, then increment the count, wrapping modulo 2^SERIAL_W.
REQ-022 SHALL set draining on accepting a tuple with in_last=1, and clear it on the output transfer of the tuple with out_last=1.
- While draining, in_ready SHALL be 0, so no tuple of the next relation enters.
REQ-023 SHALL reset the serial count to 0 when draining clears, so the next relation starts at serial 0.
REQ-024 SHALL hold out_valid and all out_* stable while out_valid && !out_ready.
REQ-025 SHALL ignore in_data and in_last when in_valid=0; bubbles SHALL NOT consume a serial number.
REQ-026 SHALL accept a tuple with in_last=1 and serial 0 as a one-tuple relation and drain it normally.
REQ-027 SHALL allow acceptance and output transfer in the same cycle; the serial count increments exactly once per acceptance.

Reset
REQ-028 SHALL, while reset=1 at a clock edge, clear all stage valid bits, draining and the serial count; out_valid=0, out_last=0, out_serialnum=0, out_hash=0, out_data=0.
REQ-029 SHALL hold in_ready=0 while reset=1; in_ready may rise in the first cycle after reset deasserts.
REQ-030 SHALL, on reset mid-operation, discard all in-flight tuples with no partial output; the next accepted tuple gets serial 0.

Structure
REQ-031 SHALL take the constants FMIX_C1 = 32'h85EBCA6B, FMIX_C2 = 32'hC2B2AE35, TUPLE_W = 64, KEY_W = 32 and HASH_W = 32 from the shared package phj_pkg.
REQ-032 SHALL be a single module; an optional sub-module fmix32_stage, instantiated per stage with a stage index, is permitted.
REQ-033 SHALL use only one clock domain and SHALL contain no memory primitives.

Verification
REQ-034 SHALL cover single tuple: SEED=0, in_data=64'h0, in_last=1, out_ready=1 -> 4 cycles later out_hash=32'h0, out_serialnum=0, out_last=1, for 1 cycle.
REQ-035 SHALL cover streaming: 16 back-to-back tuples with keys 1..16, last on the 16th -> 16 consecutive outputs; serials 0..15; hashes match the C fmix32 model; out_last only on serial 15.
REQ-036 SHALL cover backpressure: out_ready=0 for 10 cycles mid-stream -> in_ready falls once S4 is full; outputs hold stable; no loss or duplication; order preserved.
REQ-037 SHALL cover drain: in_last accepted, then in_valid held high -> in_ready=0 until the out_last transfer; the next tuple gets serial 0.
REQ-038 SHALL cover mid-operation reset: reset pulsed with 3 tuples in flight -> out_valid=0 the next cycle; the next accepted tuple emerges with serial 0.
REQ-039 SHALL cover SEED: SEED=32'hDEADBEEF, key 32'hDEADBEEF -> out_hash=32'h0.
